// File: rtl/decode_stage_pkg.sv
// Shared opcode map, FSM state type and decode-control bundle for the decode stage.
// The opcode valid mask is consumed by decode_fields when DECODE_TRAP_EN is defined.
package decode_stage_pkg;

  localparam logic [7:0] OPC_NOP     = 8'h00;
  localparam logic [7:0] OPC_ADD     = 8'h01;
  localparam logic [7:0] OPC_SUB     = 8'h02;
  localparam logic [7:0] OPC_AND     = 8'h03;
  localparam logic [7:0] OPC_OR      = 8'h04;
  localparam logic [7:0] OPC_XOR     = 8'h05;
  localparam logic [7:0] OPC_MOV     = 8'h06;
  localparam logic [7:0] OPC_LD      = 8'h07;
  localparam logic [7:0] OPC_ST      = 8'h08;
  localparam logic [7:0] OPC_PUSH    = 8'h09;
  localparam logic [7:0] OPC_POP     = 8'h0A;
  localparam logic [7:0] OPC_JMP     = 8'h0B;
  localparam logic [7:0] OPC_SET     = 8'h0C;
  localparam logic [7:0] OPC_CMP     = 8'h0D;
  localparam logic [7:0] OPC_MOVB_R0 = 8'h10;
  localparam logic [7:0] OPC_MOVB_R7 = 8'h17;
  localparam logic [7:0] OPC_ADDI    = 8'h81;
  localparam logic [7:0] OPC_SUBI    = 8'h82;
  localparam logic [7:0] OPC_ANDI    = 8'h83;
  localparam logic [7:0] OPC_ORI     = 8'h84;
  localparam logic [7:0] OPC_XORI    = 8'h85;
  localparam logic [7:0] OPC_MOVI    = 8'h86;
  localparam logic [7:0] OPC_LDI     = 8'h87;
  localparam logic [7:0] OPC_STI     = 8'h88;
  localparam logic [7:0] OPC_PUSHI   = 8'h89;
  localparam logic [7:0] OPC_JMPI    = 8'h8B;
  localparam logic [7:0] OPC_CMPI    = 8'h8D;

  typedef enum logic [0:0] {
    DEC_FIRST    = 1'b0,
    DEC_WAIT_IMM = 1'b1
  } dec_state_t;

  typedef struct packed {
    logic [7:0] alu_control;
    logic       en_immediate;
    logic       en_mem;
    logic       mem_byte;
    logic       mem_displacement;
    logic [3:0] condition;
    logic       illegal;
  } dec_ctrl_t;

  function automatic logic [255:0] build_valid_mask();
    logic [255:0] m;
    m = '0;
    m[OPC_NOP] = 1'b1;   m[OPC_ADD] = 1'b1;   m[OPC_SUB] = 1'b1;   m[OPC_AND] = 1'b1;
    m[OPC_OR] = 1'b1;    m[OPC_XOR] = 1'b1;   m[OPC_MOV] = 1'b1;   m[OPC_LD] = 1'b1;
    m[OPC_ST] = 1'b1;    m[OPC_PUSH] = 1'b1;  m[OPC_POP] = 1'b1;   m[OPC_JMP] = 1'b1;
    m[OPC_SET] = 1'b1;   m[OPC_CMP] = 1'b1;
    m[8'h10] = 1'b1; m[8'h11] = 1'b1; m[8'h12] = 1'b1; m[8'h13] = 1'b1;
    m[8'h14] = 1'b1; m[8'h15] = 1'b1; m[8'h16] = 1'b1; m[OPC_MOVB_R7] = 1'b1;
    m[OPC_ADDI] = 1'b1;  m[OPC_SUBI] = 1'b1;  m[OPC_ANDI] = 1'b1;  m[OPC_ORI] = 1'b1;
    m[OPC_XORI] = 1'b1;  m[OPC_MOVI] = 1'b1;  m[OPC_LDI] = 1'b1;   m[OPC_STI] = 1'b1;
    m[OPC_PUSHI] = 1'b1; m[OPC_JMPI] = 1'b1;  m[OPC_CMPI] = 1'b1;
    return m;
  endfunction

  localparam logic [255:0] OPC_VALID_MASK = build_valid_mask();

endpackage

// File: rtl/decode_stage_fields.sv
// Combinational word -> decode-bundle field mapping, shared by both FSM paths.
// With DECODE_TRAP_EN defined, undefined opcodes yield an illegal-only, single-word bundle.
module decode_fields
  import decode_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 3,
  parameter int unsigned SP_SEL = 7
) (
  input  logic [15:0]       insn,
  input  logic [15:0]       imm_word,
  output dec_ctrl_t         ctrl,
  output logic [REG_W-1:0]  rd_sel,
  output logic [REG_W-1:0]  rs_sel,
  output logic [DATA_W-1:0] immediate,
  output logic              two_word
);

  logic [7:0] opcode;
  logic       is_movb, is_sp, is_mem, is_disp, is_cond;

  assign opcode  = insn[15:8];
  assign is_movb = (opcode >= OPC_MOVB_R0) && (opcode <= OPC_MOVB_R7);
  assign is_sp   = opcode inside {OPC_PUSH, OPC_POP, OPC_PUSHI};
  assign is_mem  = opcode inside {OPC_ST, OPC_LD, OPC_LDI, OPC_STI, OPC_PUSH, OPC_PUSHI, OPC_POP};
  assign is_disp = opcode inside {OPC_LDI, OPC_STI};
  assign is_cond = opcode inside {OPC_JMP, OPC_JMPI, OPC_SET};

  always_comb begin
    ctrl                  = '0;
    rd_sel                = insn[REG_W-1:0];
    rs_sel                = insn[2*REG_W-1:REG_W];
    immediate             = '0;
    two_word              = opcode[7];
    ctrl.alu_control      = {1'b0, opcode[6:0]};
    ctrl.en_immediate     = opcode[7];
    ctrl.en_mem           = is_mem;
    ctrl.mem_byte         = is_mem & insn[7];
    ctrl.mem_displacement = is_disp & insn[6];
    ctrl.condition        = is_cond ? insn[6:3] : 4'h0;
    if (is_movb) begin
      ctrl.alu_control  = OPC_MOV;
      ctrl.en_immediate = 1'b1;
      rd_sel            = REG_W'(opcode - OPC_MOVB_R0);
      immediate         = DATA_W'(insn[7:0]);
    end else if (opcode[7]) begin
      immediate = DATA_W'(imm_word);
    end
    if (is_sp) rs_sel = REG_W'(SP_SEL);
`ifdef DECODE_TRAP_EN
    if (!OPC_VALID_MASK[opcode]) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
      rd_sel       = '0;
      rs_sel       = '0;
      immediate    = '0;
      two_word     = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// Handshaked decode pipeline stage: assembles one/two-word instructions into a registered bundle.
// Optional DECODE_TRAP_EN macro enables the illegal-opcode trap in decode_fields.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 3,
  parameter int unsigned SP_SEL = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_word,
  input  logic [15:0]       in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_pc,
  output logic [7:0]        alu_control,
  output logic [REG_W-1:0]  rD_sel,
  output logic [REG_W-1:0]  rS_sel,
  output logic [DATA_W-1:0] immediate,
  output logic              en_immediate,
  output logic              en_mem,
  output logic              mem_byte,
  output logic              mem_displacement,
  output logic [3:0]        condition,
  output logic              illegal
);

  dec_state_t        state, state_nxt;
  logic [15:0]       first_word, first_pc, dec_insn;
  logic              accept, load, dec_two_word;
  dec_ctrl_t         dec_ctrl, out_ctrl;
  logic [REG_W-1:0]  dec_rd, dec_rs;
  logic [DATA_W-1:0] dec_imm;

  // flush wins over everything: a word presented alongside it is never accepted
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign dec_insn = (state == DEC_WAIT_IMM) ? first_word : in_word;

  decode_fields #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W),
    .SP_SEL (SP_SEL)
  ) u_fields (
    .insn      (dec_insn),
    .imm_word  (in_word),
    .ctrl      (dec_ctrl),
    .rd_sel    (dec_rd),
    .rs_sel    (dec_rs),
    .immediate (dec_imm),
    .two_word  (dec_two_word)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    if (flush) begin
      state_nxt = DEC_FIRST;
    end else if (accept) begin
      unique case (state)
        DEC_FIRST: begin
          if (dec_two_word) state_nxt = DEC_WAIT_IMM;
          else              load      = 1'b1;
        end
        DEC_WAIT_IMM: begin
          state_nxt = DEC_FIRST;
          load      = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= DEC_FIRST;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      out_pc     <= '0;
      rD_sel     <= '0;
      rS_sel     <= '0;
      immediate  <= '0;
      first_word <= '0;
      first_pc   <= '0;
    end else begin
      if (flush || (out_valid && out_ready)) out_valid <= 1'b0;
      if (load) begin
        out_valid <= 1'b1;
        out_ctrl  <= dec_ctrl;
        out_pc    <= (state == DEC_WAIT_IMM) ? first_pc : in_pc;
        rD_sel    <= dec_rd;
        rS_sel    <= dec_rs;
        immediate <= dec_imm;
      end
      if (accept && (state == DEC_FIRST) && dec_two_word) begin
        first_word <= in_word;
        first_pc   <= in_pc;
      end
    end
  end

  assign alu_control      = out_ctrl.alu_control;
  assign en_immediate     = out_ctrl.en_immediate;
  assign en_mem           = out_ctrl.en_mem;
  assign mem_byte         = out_ctrl.mem_byte;
  assign mem_displacement = out_ctrl.mem_displacement;
  assign condition        = out_ctrl.condition;
  assign illegal          = out_ctrl.illegal;

endmodule
